// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and helpers.
// Used by the RX frame engine and the TX parity path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [31:0] PRESC_8  = 32'd8;
  localparam logic [31:0] PRESC_16 = 32'd16;
  localparam logic [31:0] PRESC_32 = 32'd32;

  // Unsupported prescale values fall back to 8.
  function automatic logic [31:0] presc_legal(
    input logic [31:0] p
  );
    if (p == PRESC_8 || p == PRESC_16 || p == PRESC_32)
      return p;
    return PRESC_8;
  endfunction

  // Zero-extension does not change the xor reduction.
  function automatic logic parity_of(
    input logic [31:0] d,
    input logic        t
  );
    return (t == PAR_EVEN) ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter, bit index and 3-sample voter.
// Ports: clk, reset(sync, low), i_start, i_active, i_rx, i_prescale ->
//        o_bit_done (edge_cnt=P-1), o_bit (voted value), o_bit_idx.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_active,
  input  logic               i_rx,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic               o_bit_done,
  output logic               o_bit,
  output logic [IDX_W-1:0]   o_bit_idx
);

  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_s0;
  logic               r_s1;
  logic               r_bit;

  logic [PRESC_W-1:0] w_last;
  logic [PRESC_W-1:0] w_half;
  logic               w_end;

  assign w_last = r_presc - PRESC_W'(1);
  assign w_half = r_presc >> 1;
  assign w_end  = i_active && (r_cnt == w_last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_bit   <= 1'b0;
    end else if (i_start) begin
      // Start edge counts as edge_cnt 0 of the start bit.
      r_presc <= PRESC_W'(presc_legal(32'(i_prescale)));
      r_cnt   <= PRESC_W'(1);
      r_idx   <= '0;
    end else if (i_active) begin
      r_cnt <= w_end ? '0 : r_cnt + PRESC_W'(1);
      if (w_end)
        r_idx <= r_idx + IDX_W'(1);
      if (r_cnt == w_half - PRESC_W'(1))
        r_s0 <= i_rx;
      if (r_cnt == w_half)
        r_s1 <= i_rx;
      if (r_cnt == w_half + PRESC_W'(1))
        r_bit <= (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
    end else begin
      r_cnt <= '0;
      r_idx <= '0;
    end
  end

  assign o_bit_done = w_end;
  assign o_bit      = r_bit;
  assign o_bit_idx  = r_idx;

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART RX frame engine (start/data/parity/stop checks).
// Ports: clk, reset(sync, low), rx_in, prescale, par_en, par_type ->
//        p_data, data_valid, par_err, stp_err (1-cycle pulses), busy.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 3);

  rx_state_e             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_armed;
  logic                  r_busy;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_par_bad;
  logic                  r_dv;
  logic                  r_pe;
  logic                  r_se;

  logic                  w_start;
  logic                  w_bit_done;
  logic                  w_bit;
  logic [IDX_W-1:0]      w_bit_idx;

  // A start needs the line to have been seen idle since reset.
  assign w_start = (r_state == ST_IDLE) && r_armed && !rx_in;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W),
    .IDX_W   (IDX_W)
  ) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_active   (r_busy),
    .i_rx       (rx_in),
    .i_prescale (prescale),
    .o_bit_done (w_bit_done),
    .o_bit      (w_bit),
    .o_bit_idx  (w_bit_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_p_data   <= '0;
      r_armed    <= 1'b0;
      r_busy     <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_par_bad  <= 1'b0;
      r_dv       <= 1'b0;
      r_pe       <= 1'b0;
      r_se       <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_se <= 1'b0;
      if (rx_in)
        r_armed <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_START;
            r_busy     <= 1'b1;
            r_par_en   <= par_en;
            r_par_type <= par_type;
            r_par_bad  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            if (w_bit) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
            if (w_bit_idx == IDX_W'(DATA_WIDTH))
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            r_par_bad <= w_bit != parity_of(32'(r_shift), r_par_type);
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_se    <= !w_bit;
            r_pe    <= r_par_bad;
            if (w_bit && !r_par_bad) begin
              r_p_data <= r_shift;
              r_dv     <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign p_data     = r_p_data;
  assign data_valid = r_dv;
  assign par_err    = r_pe;
  assign stp_err    = r_se;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: table-driven frames with a pulse scoreboard,
// plus glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx_frame;

  logic       clk;
  logic       reset;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_type;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  uart_rx_frame #(
    .DATA_WIDTH (8),
    .PRESC_W    (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_type   (par_type),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         presc;
    int         p;
    bit         pen;
    bit         ptype;
    logic [7:0] d;
    bit         flip;
    bit         stop;
    bit         corr;
    bit         tog;
    bit         dv;
    bit         pe;
    bit         se;
  } vec_t;

  typedef struct {
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [7:0] model_pdata = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulses are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (data_valid || par_err || stp_err) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: dv=%0b pe=%0b se=%0b cyc=%0d",
                 data_valid, par_err, stp_err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (data_valid !== e.dv || par_err !== e.pe ||
            stp_err !== e.se || p_data !== e.d ||
            cyc != e.cyc || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL pulse: got dv=%0b pe=%0b se=%0b data=%0h cyc=%0d busy=%0b expected dv=%0b pe=%0b se=%0b data=%0h cyc=%0d busy=0",
                   data_valid, par_err, stp_err, p_data, cyc, busy,
                   e.dv, e.pe, e.se, e.d, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v);
    bit   bq[$];
    int   n;
    exp_t e;
    bq.push_back(1'b0);
    for (int i = 0; i < 8; i++) bq.push_back(v.d[i]);
    if (v.pen)
      bq.push_back((v.ptype ? ~^v.d : ^v.d) ^ v.flip);
    bq.push_back(v.stop);
    n = bq.size();
    if (v.dv || v.pe || v.se) begin
      e.dv  = v.dv;
      e.pe  = v.pe;
      e.se  = v.se;
      e.d   = v.dv ? v.d : model_pdata;
      e.cyc = cyc + 1 + n * v.p - 1;
      sb.push_back(e);
      if (v.dv) model_pdata = v.d;
    end
    prescale = 6'(v.presc);
    par_en   = v.pen;
    par_type = v.ptype;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < v.p; k++) begin
        rx_in = bq[i] ^ (v.corr && k == v.p / 2);
        if (v.tog && i == 0 && k == 1) begin
          par_en   = ~v.pen;
          par_type = ~v.ptype;
        end
        tick();
      end
    end
    rx_in = 1'b1;
  endtask

  vec_t vt[9];
  vec_t va;
  vec_t vb;

  initial begin
    vt[0] = '{8,  8,  1, 0, 8'hA5, 0, 1, 0, 0, 1, 0, 0};
    vt[1] = '{16, 16, 1, 1, 8'h3C, 1, 1, 0, 0, 0, 1, 0};
    vt[2] = '{32, 32, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 1};
    vt[3] = '{16, 16, 0, 0, 8'h5A, 0, 1, 0, 1, 1, 0, 0};
    vt[4] = '{8,  8,  1, 1, 8'h01, 1, 0, 0, 0, 0, 1, 1};
    vt[5] = '{20, 8,  0, 0, 8'hC3, 0, 1, 0, 0, 1, 0, 0};
    vt[6] = '{32, 32, 1, 0, 8'h00, 0, 1, 1, 0, 1, 0, 0};
    vt[7] = '{8,  8,  1, 0, 8'h7E, 1, 1, 0, 0, 0, 1, 0};
    vt[8] = '{0,  8,  1, 1, 8'h96, 0, 1, 1, 1, 1, 0, 0};

    reset    = 1'b0;
    rx_in    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_type = 1'b0;
    repeat (3) tick();
    chk("rst_p_data", 32'(p_data), 32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
    chk("rst_par_err", 32'(par_err), 32'h0);
    chk("rst_stp_err", 32'(stp_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) begin
      send_frame(vt[i]);
      repeat (3) tick();
      chk($sformatf("vec%0d_sb_drained", i), 32'(sb.size()), 32'h0);
    end

    // Two-cycle low glitch on the idle line.
    prescale = 6'd8;
    rx_in = 1'b0;
    tick();
    chk("glitch_busy_e0", 32'(busy), 32'h1);
    tick();
    rx_in = 1'b1;
    repeat (5) tick();
    chk("glitch_busy_e6", 32'(busy), 32'h1);
    tick();
    chk("glitch_busy_e7", 32'(busy), 32'h0);
    repeat (4) tick();
    chk("glitch_no_pulse", 32'(sb.size()), 32'h0);

    // Back-to-back frames with one bad sample per bit.
    va = '{8, 8, 1, 0, 8'h00, 0, 1, 1, 0, 1, 0, 0};
    vb = '{8, 8, 1, 0, 8'h81, 0, 1, 1, 0, 1, 0, 0};
    send_frame(va);
    send_frame(vb);
    repeat (3) tick();
    chk("b2b_sb_drained", 32'(sb.size()), 32'h0);
    chk("b2b_p_data", 32'(p_data), 32'h81);

    // Reset in the middle of a frame with the line held low.
    prescale = 6'd8;
    par_en   = 1'b1;
    rx_in    = 1'b0;
    repeat (40) tick();
    chk("midrst_busy_before", 32'(busy), 32'h1);
    reset = 1'b0;
    tick();
    model_pdata = 8'h00;
    chk("midrst_p_data", 32'(p_data), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_pulses", 32'({data_valid, par_err, stp_err}), 32'h0);
    reset = 1'b1;
    repeat (20) tick();
    chk("midrst_no_start", 32'(busy), 32'h0);
    rx_in = 1'b1;
    tick();
    chk("midrst_armed_idle", 32'(busy), 32'h0);
    send_frame(vt[0]);
    repeat (3) tick();
    chk("midrst_frame_drained", 32'(sb.size()), 32'h0);
    chk("midrst_frame_data", 32'(p_data), 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
